// File: rtl/branch_history_predictor.sv
// Direct-mapped BHT+BTB branch predictor: 2-bit saturating counters with tag and target,
// combinational fetch lookup, execute-stage update, init sweep FSM and saturating statistics.
module branch_history_predictor #(
   parameter int unsigned IDX_W    = 6,
   parameter int unsigned TAG_W    = 8,
   parameter logic [1:0]  CNT_INIT = 2'b01
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] f_pc,
   input  logic        f_is_branch,
   output logic        f_pred_taken,
   output logic        f_btb_hit,
   output logic [31:0] f_pred_target,
   input  logic        e_valid,
   input  logic [31:0] e_pc,
   input  logic        e_taken,
   input  logic [31:0] e_target,
   input  logic        e_mispredict,
   input  logic        tbl_flush,
   input  logic        stat_clr,
   output logic        init_busy,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispred
);

   localparam int unsigned N = 2 ** IDX_W;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t             r_state, w_state_nxt;
   logic [IDX_W-1:0]   r_idx, w_idx_nxt;

   logic               r_valid  [N];
   logic [TAG_W-1:0]   r_tag    [N];
   logic [1:0]         r_cnt    [N];
   logic [31:0]        r_target [N];

   logic [31:0]        r_branches, r_mispred;

   logic [IDX_W-1:0]   w_f_idx, w_e_idx;
   logic [TAG_W-1:0]   w_f_tag, w_e_tag;
   logic               w_e_hit, w_upd;
   logic [1:0]         w_cnt_old, w_cnt_new;
   logic               w_unused;

   assign w_f_idx  = f_pc[IDX_W-1:0];
   assign w_f_tag  = f_pc[IDX_W+TAG_W-1:IDX_W];
   assign w_e_idx  = e_pc[IDX_W-1:0];
   assign w_e_tag  = e_pc[IDX_W+TAG_W-1:IDX_W];
   assign w_unused = ^{f_pc[31:IDX_W+TAG_W], e_pc[31:IDX_W+TAG_W]};

   assign init_busy = (r_state == ST_INIT);

   // Fetch lookup sees pre-update contents; no bypass from a same-cycle update.
   assign f_btb_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag) && !init_busy;
   assign f_pred_taken  = f_btb_hit && f_is_branch && r_cnt[w_f_idx][1];
   assign f_pred_target = f_btb_hit ? r_target[w_f_idx] : (f_pc + 32'd1);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Next state: sweep one entry per cycle, flush restarts the sweep from index 0
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         ST_INIT: begin
            if (tbl_flush) begin
               w_idx_nxt = '0;
            end else if (r_idx == IDX_W'(N - 1)) begin
               w_state_nxt = ST_RUN;
               w_idx_nxt   = '0;
            end else begin
               w_idx_nxt = r_idx + IDX_W'(1);
            end
         end
         ST_RUN: begin
            if (tbl_flush) begin
               w_state_nxt = ST_INIT;
               w_idx_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
            w_idx_nxt   = '0;
         end
      endcase
   end

   assign w_upd     = (r_state == ST_RUN) && e_valid;
   assign w_e_hit   = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);
   assign w_cnt_old = r_cnt[w_e_idx];

   // Counter update: saturate on hit, fresh weak state on allocation
   always_comb begin
      w_cnt_new = w_cnt_old;
      if (w_e_hit) begin
         if (e_taken) w_cnt_new = (w_cnt_old == 2'b11) ? 2'b11 : w_cnt_old + 2'b01;
         else         w_cnt_new = (w_cnt_old == 2'b00) ? 2'b00 : w_cnt_old - 2'b01;
      end else begin
         w_cnt_new = e_taken ? 2'b10 : 2'b01;
      end
   end

   // Table storage has no reset; its contents are masked by init_busy until the sweep ends
   always_ff @(posedge clk) begin
      if (r_state == ST_INIT) begin
         r_valid[r_idx] <= 1'b0;
         r_cnt[r_idx]   <= CNT_INIT;
      end else if (w_upd) begin
         r_valid[w_e_idx] <= 1'b1;
         r_tag[w_e_idx]   <= w_e_tag;
         r_cnt[w_e_idx]   <= w_cnt_new;
         if (!w_e_hit || e_taken) r_target[w_e_idx] <= e_target;
      end
   end

   // Saturating statistics; clear wins over increment, flush leaves them alone
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_branches <= '0;
         r_mispred  <= '0;
      end else if (stat_clr) begin
         r_branches <= '0;
         r_mispred  <= '0;
      end else if (w_upd) begin
         if (r_branches != 32'hFFFF_FFFF) r_branches <= r_branches + 32'd1;
         if (e_mispredict && (r_mispred != 32'hFFFF_FFFF)) r_mispred <= r_mispred + 32'd1;
      end
   end

   assign stat_branches = r_branches;
   assign stat_mispred  = r_mispred;

endmodule

// File: tb/tb_branch_history_predictor.sv
// Scoreboard bench for branch_history_predictor: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_history_predictor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] f_pc;
   logic        f_is_branch;
   logic        f_pred_taken;
   logic        f_btb_hit;
   logic [31:0] f_pred_target;
   logic        e_valid;
   logic [31:0] e_pc;
   logic        e_taken;
   logic [31:0] e_target;
   logic        e_mispredict;
   logic        tbl_flush;
   logic        stat_clr;
   logic        init_busy;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispred;

   branch_history_predictor dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .f_pc          (f_pc),
      .f_is_branch   (f_is_branch),
      .f_pred_taken  (f_pred_taken),
      .f_btb_hit     (f_btb_hit),
      .f_pred_target (f_pred_target),
      .e_valid       (e_valid),
      .e_pc          (e_pc),
      .e_taken       (e_taken),
      .e_target      (e_target),
      .e_mispredict  (e_mispredict),
      .tbl_flush     (tbl_flush),
      .stat_clr      (stat_clr),
      .init_busy     (init_busy),
      .stat_branches (stat_branches),
      .stat_mispred  (stat_mispred)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          is_stat;
      logic        busy;
      logic        hit;
      logic        taken;
      logic [31:0] tgt;
      logic [31:0] br;
      logic [31:0] mp;
   } exp_t;

   exp_t q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   // Monitor: consumes every expectation queued during the current cycle
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_total++;
         if (e.is_stat) begin
            if (stat_branches === e.br && stat_mispred === e.mp) n_pass++;
            else $display("FAIL %s: got branches=%0d mispred=%0d, expected branches=%0d mispred=%0d",
                          e.name, stat_branches, stat_mispred, e.br, e.mp);
         end else begin
            if (init_busy === e.busy && f_btb_hit === e.hit && f_pred_taken === e.taken &&
                f_pred_target === e.tgt) n_pass++;
            else $display("FAIL %s: got busy=%b hit=%b taken=%b tgt=%h, expected busy=%b hit=%b taken=%b tgt=%h",
                          e.name, init_busy, f_btb_hit, f_pred_taken, f_pred_target,
                          e.busy, e.hit, e.taken, e.tgt);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      e_valid      = 1'b0;
      e_mispredict = 1'b0;
      tbl_flush    = 1'b0;
      stat_clr     = 1'b0;
   endtask

   task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic mp);
      e_valid      = 1'b1;
      e_pc         = pc;
      e_taken      = tk;
      e_target     = tg;
      e_mispredict = mp;
   endtask

   task automatic look(input logic [31:0] pc, input logic br);
      f_pc        = pc;
      f_is_branch = br;
   endtask

   task automatic exp_lk(input string nm, input logic busy, input logic hit, input logic tk,
                         input logic [31:0] tg);
      exp_t e;
      e.name = nm; e.is_stat = 1'b0; e.busy = busy; e.hit = hit; e.taken = tk; e.tgt = tg;
      e.br = '0; e.mp = '0;
      q.push_back(e);
   endtask

   task automatic exp_st(input string nm, input logic [31:0] br, input logic [31:0] mp);
      exp_t e;
      e.name = nm; e.is_stat = 1'b1; e.busy = 1'b0; e.hit = 1'b0; e.taken = 1'b0; e.tgt = '0;
      e.br = br; e.mp = mp;
      q.push_back(e);
   endtask

   initial begin
      rst_n = 1'b0;
      f_pc = '0; f_is_branch = 1'b0;
      e_pc = '0; e_taken = 1'b0; e_target = '0;
      idle();
      repeat (3) step();

      look(32'h10, 1'b1);
      exp_lk("reset", 1'b1, 1'b0, 1'b0, 32'h11);
      exp_st("reset_stats", 0, 0);
      step();

      // Sweep lasts exactly 64 cycles after reset release
      rst_n = 1'b1;
      for (int i = 0; i < 64; i++) begin
         look(32'h100 + 32'(i), 1'b1);
         exp_lk("init_sweep", 1'b1, 1'b0, 1'b0, 32'h101 + 32'(i));
         step();
      end
      look(32'h40, 1'b1);
      exp_lk("init_done", 1'b0, 1'b0, 1'b0, 32'h41);

      // First taken update: same-cycle lookup still misses
      set_upd(32'h40, 1'b1, 32'h30, 1'b1);
      exp_lk("first_upd_old", 1'b0, 1'b0, 1'b0, 32'h41);
      step();
      idle();
      exp_lk("first_taken", 1'b0, 1'b1, 1'b1, 32'h30);
      step();

      // Saturate at 11, then decrement twice to 01
      repeat (3) begin
         set_upd(32'h40, 1'b1, 32'h30, 1'b0);
         step();
      end
      idle();
      exp_lk("sat_taken", 1'b0, 1'b1, 1'b1, 32'h30);
      step();
      look(32'h40, 1'b0);
      exp_lk("not_branch", 1'b0, 1'b1, 1'b0, 32'h30);
      step();
      set_upd(32'h40, 1'b0, 32'h99, 1'b1);
      step();
      idle();
      look(32'h40, 1'b1);
      exp_lk("sat_dec1", 1'b0, 1'b1, 1'b1, 32'h30);
      step();
      set_upd(32'h40, 1'b0, 32'h99, 1'b1);
      step();
      idle();
      exp_lk("weak_nt", 1'b0, 1'b1, 1'b0, 32'h30);
      step();

      // Alias: 0x140 shares index 0 with 0x40
      set_upd(32'h140, 1'b1, 32'h200, 1'b1);
      step();
      idle();
      look(32'h40, 1'b1);
      exp_lk("alias_evict", 1'b0, 1'b0, 1'b0, 32'h41);
      step();
      look(32'h140, 1'b1);
      exp_lk("alias_new", 1'b0, 1'b1, 1'b1, 32'h200);
      step();

      // Not-taken allocation starts at 01, then one taken moves to 10 with new target
      set_upd(32'h5, 1'b0, 32'h77, 1'b0);
      step();
      idle();
      look(32'h5, 1'b1);
      exp_lk("alloc_nt", 1'b0, 1'b1, 1'b0, 32'h77);
      step();
      set_upd(32'h5, 1'b1, 32'h78, 1'b0);
      step();
      idle();
      exp_lk("nt_to_t", 1'b0, 1'b1, 1'b1, 32'h78);
      step();

      // Same-cycle lookup/update of one index: old then new
      look(32'h140, 1'b1);
      set_upd(32'h140, 1'b0, 32'h0, 1'b1);
      exp_lk("same_cycle_old", 1'b0, 1'b1, 1'b1, 32'h200);
      step();
      idle();
      exp_lk("same_cycle_new", 1'b0, 1'b1, 1'b0, 32'h200);
      step();

      // Stats: clear beats a same-cycle increment, then 5 branches with 2 mispredicts
      stat_clr = 1'b1;
      set_upd(32'h300, 1'b1, 32'h310, 1'b1);
      step();
      stat_clr = 1'b0;
      set_upd(32'h301, 1'b1, 32'h311, 1'b1);
      exp_st("clr_priority", 0, 0);
      step();
      set_upd(32'h302, 1'b1, 32'h312, 1'b0); step();
      set_upd(32'h303, 1'b0, 32'h313, 1'b0); step();
      set_upd(32'h304, 1'b1, 32'h314, 1'b1); step();
      set_upd(32'h305, 1'b0, 32'h315, 1'b0); step();
      idle();
      exp_st("stats_5_2", 5, 2);
      step();

      // Flush in RUN counts its same-cycle branch; flush in INIT restarts the sweep
      tbl_flush = 1'b1;
      set_upd(32'h306, 1'b1, 32'h316, 1'b0);
      step();
      for (int i = 0; i < 85; i++) begin
         tbl_flush = (i == 20);
         set_upd(32'h40, 1'b1, 32'h30, 1'b1);
         look(32'h40, 1'b1);
         exp_lk("flush_sweep", 1'b1, 1'b0, 1'b0, 32'h41);
         if (i == 84) exp_st("stats_kept", 6, 2);
         step();
      end
      idle();
      exp_lk("flush_done", 1'b0, 1'b0, 1'b0, 32'h41);
      exp_st("stats_after_init", 6, 2);
      step();

      // Asynchronous reset takes effect before the next clock edge
      rst_n = 1'b0;
      exp_lk("async_rst", 1'b1, 1'b0, 1'b0, 32'h41);
      exp_st("async_rst_stats", 0, 0);
      step();
      rst_n = 1'b1;
      step();

      n_total++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
